// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the memory-port
// arbiter and main memory. The arbiter connects through the slave modport;
// the requesters and memory model connect through the master modport.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int ACCESS_SIZE  = 2
);
    // instruction-fetch requester (read-only)
    logic                    i_req;
    logic [ADDRESS_SIZE-1:0] i_addr;
    logic [ACCESS_SIZE-1:0]  i_acc_size;
    logic                    i_grant;
    logic                    i_ack;
    logic                    i_rvalid;
    logic [DATA_SIZE-1:0]    i_rdata;
    logic                    i_done;

    // load/store requester (read/write)
    logic                    d_req;
    logic [ADDRESS_SIZE-1:0] d_addr;
    logic [ACCESS_SIZE-1:0]  d_acc_size;
    logic                    d_wren;
    logic [DATA_SIZE-1:0]    d_wdata;
    logic                    d_grant;
    logic                    d_ack;
    logic                    d_rvalid;
    logic [DATA_SIZE-1:0]    d_rdata;
    logic                    d_done;

    // main memory port
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0]    mem_d_in;
    logic [DATA_SIZE-1:0]    mem_d_out;
    logic [ACCESS_SIZE-1:0]  mem_acc_size;
    logic                    mem_wren;
    logic                    mem_enable;

    modport slave (
        input  i_req, i_addr, i_acc_size,
        output i_grant, i_ack, i_rvalid, i_rdata, i_done,
        input  d_req, d_addr, d_acc_size, d_wren, d_wdata,
        output d_grant, d_ack, d_rvalid, d_rdata, d_done,
        output mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable,
        input  mem_d_out
    );

    modport master (
        output i_req, i_addr, i_acc_size,
        input  i_grant, i_ack, i_rvalid, i_rdata, i_done,
        output d_req, d_addr, d_acc_size, d_wren, d_wdata,
        input  d_grant, d_ack, d_rvalid, d_rdata, d_done,
        input  mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable,
        output mem_d_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: shares one single-word memory port between the
// instruction-fetch side and the load/store side. Each granted burst of
// 1/4/8/16 words is played out as back-to-back single-word accesses.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests; otherwise the data side always has priority.
//
// state | meaning
// IDLE  | no grant; sample requests, pick winner, latch burst
// XFER  | one memory beat per cycle for the granted side
// DONE  | one-cycle done pulse; grant released on exit
module mem_port_arbiter #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int ACCESS_SIZE  = 2
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_XFER = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]              r_state;
    logic [3:0]              r_beat;
    logic [3:0]              r_last_beat;
    logic                    r_wren;
    logic                    r_i_grant;
    logic                    r_d_grant;
    logic                    r_i_rvalid;
    logic                    r_d_rvalid;
    logic [DATA_SIZE-1:0]    r_i_rdata;
    logic [DATA_SIZE-1:0]    r_d_rdata;
    logic                    r_i_done;
    logic                    r_d_done;
    logic [ADDRESS_SIZE-1:0] r_mem_addr;
    logic                    r_mem_wren;
    logic                    r_mem_enable;

    logic                    w_any_req;
    logic                    w_pick_d;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_rd_beat;
    logic                    w_new_wren;
    logic [ADDRESS_SIZE-1:0] w_req_addr;
    logic [ACCESS_SIZE-1:0]  w_req_size;

    // burst length code to index of the final beat (N-1)
    function automatic logic [3:0] size_to_last(input logic [ACCESS_SIZE-1:0] code);
        logic [3:0] last;
        case (code)
            ACCESS_SIZE'(0): last = 4'd0;
            ACCESS_SIZE'(1): last = 4'd3;
            ACCESS_SIZE'(2): last = 4'd7;
            default:         last = 4'd15;
        endcase
        return last;
    endfunction

    assign w_any_req = bus.i_req | bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side won the most recent arbitration
    logic r_last_d;

    assign w_pick_d = bus.d_req & (~bus.i_req | ~r_last_d);

    // remember the last winner so a tie goes to the other side next time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    assign w_req_addr = w_pick_d ? bus.d_addr : bus.i_addr;
    assign w_req_size = w_pick_d ? bus.d_acc_size : bus.i_acc_size;
    assign w_new_wren = w_pick_d & bus.d_wren;

    assign w_xfer    = (r_state == ST_XFER);
    assign w_last    = (r_beat == r_last_beat);
    assign w_rd_beat = w_xfer & ~r_wren;

    // burst sequencer: arbitration, beat stepping and done generation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_beat       <= 4'd0;
            r_last_beat  <= 4'd0;
            r_wren       <= 1'b0;
            r_i_grant    <= 1'b0;
            r_d_grant    <= 1'b0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wren   <= 1'b0;
            r_mem_enable <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ST_XFER;
                        r_beat       <= 4'd0;
                        r_last_beat  <= size_to_last(w_req_size);
                        r_wren       <= w_new_wren;
                        r_i_grant    <= ~w_pick_d;
                        r_d_grant    <= w_pick_d;
                        r_mem_addr   <= w_req_addr & ~ADDRESS_SIZE'(3);
                        r_mem_wren   <= w_new_wren;
                        r_mem_enable <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_mem_wren   <= 1'b0;
                        r_mem_enable <= 1'b0;
                        r_i_done     <= r_i_grant;
                        r_d_done     <= r_d_grant;
                    end else begin
                        r_beat     <= r_beat + 4'd1;
                        r_mem_addr <= r_mem_addr + ADDRESS_SIZE'(4);
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_i_grant <= 1'b0;
                    r_d_grant <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_i_grant <= 1'b0;
                    r_d_grant <= 1'b0;
                end
            endcase
        end
    end

    // read return: capture memory data for the beat presented this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= w_rd_beat & r_i_grant;
            r_d_rvalid <= w_rd_beat & r_d_grant;
            if (w_rd_beat && r_i_grant) begin
                r_i_rdata <= bus.mem_d_out;
            end
            if (w_rd_beat && r_d_grant) begin
                r_d_rdata <= bus.mem_d_out;
            end
        end
    end

    // ack and write data follow the beat combinationally so the requester
    // can present the next word on the cycle after each ack
    assign bus.i_ack    = w_xfer & r_i_grant;
    assign bus.d_ack    = w_xfer & r_d_grant;
    assign bus.mem_d_in = (w_xfer && r_d_grant && r_wren) ? bus.d_wdata : '0;

    assign bus.i_grant  = r_i_grant;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.i_done   = r_i_done;

    assign bus.d_grant  = r_d_grant;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_done   = r_d_done;

    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wren     = r_mem_wren;
    assign bus.mem_enable   = r_mem_enable;
    assign bus.mem_acc_size = '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Stimulus computes the expected
// memory accesses, read data, grant order and done timing from the burst
// rules and queues them; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] addr;
        bit          wren;
        logic [31:0] wdata;
        bit          side;    // 1 = data side
    } acc_t;

    typedef struct {
        bit side;
        int n;
        bit rd;
    } done_t;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .ACCESS_SIZE(2)) bus ();

    mem_port_arbiter #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .ACCESS_SIZE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    acc_t        acc_q[$];
    logic [31:0] rd_i_q[$];
    logic [31:0] rd_d_q[$];
    done_t       done_q[$];
    bit          grant_q[$];

    logic [31:0] ref_mem  [1024];
    logic [31:0] phys_mem [1024];
    logic [31:0] wr_words [16];
    bit          rr_last_d = 1'b0;
    bit          pend_i, pend_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h11223344 : (32'h5A5A0000 ^ (i * 32'h01010101));
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // memory: combinational read of the presented address, write on posedge
    assign bus.mem_d_out = phys_mem[bus.mem_addr[11:2]];
    initial begin
        for (int i = 0; i < 1024; i++) phys_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_enable && bus.mem_wren) phys_mem[bus.mem_addr[11:2]] = bus.mem_d_in;
        end
    end

    // monitor
    int   mcycle = 0;
    int   g_cyc_i = 0, g_cyc_d = 0;
    bit   prev_ig = 0, prev_dg = 0;
    acc_t ma;
    done_t md;
    bit   mside;

    always @(negedge clk) begin
        mcycle++;
        if (rst_n === 1'b1) begin
            if (bus.i_grant && !prev_ig) begin
                g_cyc_i = mcycle;
                if (grant_q.size() == 0) chk(0, "unexpected_i_grant", 1, 0);
                else begin mside = grant_q.pop_front(); chk(mside == 1'b0, "grant_order_i", 0, 32'(mside)); end
            end
            if (bus.d_grant && !prev_dg) begin
                g_cyc_d = mcycle;
                if (grant_q.size() == 0) chk(0, "unexpected_d_grant", 1, 0);
                else begin mside = grant_q.pop_front(); chk(mside == 1'b1, "grant_order_d", 1, 32'(mside)); end
            end
            if (bus.i_grant && bus.d_grant) chk(0, "both_grants", 1, 0);
            if (bus.mem_enable) begin
                if (acc_q.size() == 0) chk(0, "unexpected_access", bus.mem_addr, 0);
                else begin
                    ma = acc_q.pop_front();
                    chk(bus.mem_addr == ma.addr, "mem_addr", bus.mem_addr, ma.addr);
                    chk(bus.mem_wren == ma.wren, "mem_wren", 32'(bus.mem_wren), 32'(ma.wren));
                    chk(bus.mem_acc_size == 2'b00, "mem_acc_size", 32'(bus.mem_acc_size), 0);
                    chk(bus.d_ack == ma.side && bus.i_ack == !ma.side, "ack_side",
                        {30'd0, bus.d_ack, bus.i_ack}, ma.side ? 32'd2 : 32'd1);
                    if (ma.wren) chk(bus.mem_d_in == ma.wdata, "mem_d_in", bus.mem_d_in, ma.wdata);
                end
            end else if (bus.i_ack || bus.d_ack) begin
                chk(0, "ack_without_access", {30'd0, bus.d_ack, bus.i_ack}, 0);
            end
            if (bus.i_rvalid) begin
                if (rd_i_q.size() == 0) chk(0, "unexpected_i_rvalid", bus.i_rdata, 0);
                else begin ma.wdata = rd_i_q.pop_front(); chk(bus.i_rdata == ma.wdata, "i_rdata", bus.i_rdata, ma.wdata); end
            end
            if (bus.d_rvalid) begin
                if (rd_d_q.size() == 0) chk(0, "unexpected_d_rvalid", bus.d_rdata, 0);
                else begin ma.wdata = rd_d_q.pop_front(); chk(bus.d_rdata == ma.wdata, "d_rdata", bus.d_rdata, ma.wdata); end
            end
            if (bus.i_done || bus.d_done) begin
                if (done_q.size() == 0) chk(0, "unexpected_done", {30'd0, bus.d_done, bus.i_done}, 0);
                else begin
                    md = done_q.pop_front();
                    chk(bus.d_done == md.side && bus.i_done == !md.side, "done_side",
                        {30'd0, bus.d_done, bus.i_done}, md.side ? 32'd2 : 32'd1);
                    chk((mcycle - (md.side ? g_cyc_d : g_cyc_i)) == md.n, "done_latency",
                        32'(mcycle - (md.side ? g_cyc_d : g_cyc_i)), 32'(md.n));
                    chk((md.side ? bus.d_rvalid : bus.i_rvalid) == md.rd, "last_rvalid_with_done",
                        32'(md.side ? bus.d_rvalid : bus.i_rvalid), 32'(md.rd));
                end
            end
        end
        prev_ig = bus.i_grant;
        prev_dg = bus.d_grant;
    end

    task automatic push_burst(input bit side, input logic [31:0] addr, input logic [1:0] sz, input bit wren);
        int n;
        logic [31:0] base, a;
        acc_t e;
        done_t d;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
        base = addr & 32'hFFFF_FFFC;
        grant_q.push_back(side);
        for (int k = 0; k < n; k++) begin
            a = base + 32'(4 * k);
            e.addr = a; e.wren = wren; e.side = side;
            e.wdata = wren ? wr_words[k] : 32'd0;
            acc_q.push_back(e);
            if (wren) ref_mem[a[11:2]] = wr_words[k];
            else if (side) rd_d_q.push_back(ref_mem[a[11:2]]);
            else rd_i_q.push_back(ref_mem[a[11:2]]);
        end
        d.side = side; d.n = n; d.rd = !wren;
        done_q.push_back(d);
    endtask

    task automatic serve(input string name);
        int cyc = 0;
        int widx = 0;
        bit ackd;
        while ((pend_i || pend_d) && cyc < 200) begin
            @(negedge clk);
            ackd = bus.d_ack;
            if (bus.i_done) begin bus.i_req = 1'b0; pend_i = 0; end
            if (bus.d_done) begin bus.d_req = 1'b0; pend_d = 0; end
            @(posedge clk); #1;
            if (ackd && widx < 15) begin widx++; bus.d_wdata = wr_words[widx]; end
            cyc++;
        end
        if (pend_i || pend_d) begin
            chk(0, {name, "_timeout"}, 32'(cyc), 200);
            bus.i_req = 1'b0; bus.d_req = 1'b0; pend_i = 0; pend_d = 0;
        end
    endtask

    task automatic burst_pair(input bit i_en, input logic [31:0] ia, input logic [1:0] isz,
                              input bit d_en, input logic [31:0] da, input logic [1:0] dsz,
                              input bit dw, input string name);
        bit d_first;
`ifdef ARB_ROUND_ROBIN_EN
        d_first = d_en && (!i_en || !rr_last_d);
`else
        d_first = d_en;
`endif
        if (d_first) begin
            push_burst(1'b1, da, dsz, dw);
            if (i_en) push_burst(1'b0, ia, isz, 1'b0);
        end else begin
            push_burst(1'b0, ia, isz, 1'b0);
            if (d_en) push_burst(1'b1, da, dsz, dw);
        end
        rr_last_d = (i_en && d_en) ? !d_first : d_first;
        bus.i_addr = ia; bus.i_acc_size = isz;
        bus.d_addr = da; bus.d_acc_size = dsz; bus.d_wren = dw;
        bus.d_wdata = wr_words[0];
        bus.i_req = i_en; bus.d_req = d_en;
        pend_i = i_en; pend_d = d_en;
        serve(name);
    endtask

    task automatic check_all_zero(input string name);
        chk(bus.i_grant == 0, {name, "_i_grant"}, 32'(bus.i_grant), 0);
        chk(bus.d_grant == 0, {name, "_d_grant"}, 32'(bus.d_grant), 0);
        chk(bus.i_ack == 0 && bus.d_ack == 0, {name, "_ack"}, {30'd0, bus.d_ack, bus.i_ack}, 0);
        chk(bus.i_rvalid == 0 && bus.d_rvalid == 0, {name, "_rvalid"}, {30'd0, bus.d_rvalid, bus.i_rvalid}, 0);
        chk(bus.i_rdata == 0, {name, "_i_rdata"}, bus.i_rdata, 0);
        chk(bus.d_rdata == 0, {name, "_d_rdata"}, bus.d_rdata, 0);
        chk(bus.i_done == 0 && bus.d_done == 0, {name, "_done"}, {30'd0, bus.d_done, bus.i_done}, 0);
        chk(bus.mem_addr == 0, {name, "_mem_addr"}, bus.mem_addr, 0);
        chk(bus.mem_wren == 0, {name, "_mem_wren"}, 32'(bus.mem_wren), 0);
        chk(bus.mem_enable == 0, {name, "_mem_enable"}, 32'(bus.mem_enable), 0);
    endtask

    initial begin
        int acks, cyc;
        logic [1:0]  isz, dsz;
        logic [31:0] ia, da;
        bit ie, de, dw;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 16; i++) wr_words[i] = 32'd0;
        pend_i = 0; pend_d = 0;

        // reset with an instruction request already pending
        rst_n = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h8002_0003; bus.i_acc_size = 2'b00;
        bus.d_req = 1'b0; bus.d_addr = 32'd0; bus.d_acc_size = 2'b00;
        bus.d_wren = 1'b0; bus.d_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        push_burst(1'b0, 32'h8002_0003, 2'b00, 1'b0);
        rr_last_d = 1'b0;
        pend_i = 1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk(bus.i_grant == 1'b1, "grant_after_reset", 32'(bus.i_grant), 1);
        serve("single_read");

        // 4-word write then readback
        for (int k = 0; k < 4; k++) wr_words[k] = 32'hA0 + 32'(k);
        burst_pair(0, 0, 0, 1, 32'h8002_0010, 2'b01, 1, "write4");
        burst_pair(0, 0, 0, 1, 32'h8002_0010, 2'b01, 0, "readback4");
        burst_pair(1, 32'h8002_0012, 2'b01, 0, 0, 0, 0, "i_readback4");

        // contention, repeated, then after a lone data request
        burst_pair(1, 32'h8002_0040, 2'b00, 1, 32'h8002_0044, 2'b00, 0, "contend1");
        burst_pair(1, 32'h8002_0048, 2'b00, 1, 32'h8002_004C, 2'b00, 0, "contend2");
        burst_pair(0, 0, 0, 1, 32'h8002_0050, 2'b00, 0, "lone_d");
        burst_pair(1, 32'h8002_0054, 2'b00, 1, 32'h8002_0058, 2'b00, 0, "contend3");

        // address wrap
        burst_pair(0, 0, 0, 1, 32'hFFFF_FFF8, 2'b01, 0, "wrap");

        // randomized bursts
        for (int it = 0; it < 30; it++) begin
            ie = 1'($urandom); de = 1'($urandom);
            if (!ie && !de) de = 1'b1;
            isz = 2'($urandom); dsz = 2'($urandom); dw = 1'($urandom);
            ia = 32'h8002_0000 | ($urandom & 32'hFFF);
            da = 32'h8002_0000 | ($urandom & 32'hFFF);
            for (int k = 0; k < 16; k++) wr_words[k] = $urandom;
            burst_pair(ie, ia, isz, de, da, dsz, dw, "random");
        end

        // reset in the middle of a 16-word read
        push_burst(1'b1, 32'h8002_0100, 2'b11, 1'b0);
        bus.d_addr = 32'h8002_0100; bus.d_acc_size = 2'b11; bus.d_wren = 1'b0;
        bus.d_req = 1'b1;
        acks = 0; cyc = 0;
        while (acks < 6 && cyc < 100) begin
            @(negedge clk);
            if (bus.d_ack) acks++;
            cyc++;
        end
        chk(acks == 6, "midrst_reach_beat5", 32'(acks), 6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        bus.d_req = 1'b0;
        acc_q.delete(); rd_i_q.delete(); rd_d_q.delete(); done_q.delete(); grant_q.delete();
        @(negedge clk);
        chk(bus.d_done == 0, "midrst_no_done", 32'(bus.d_done), 0);
        rst_n = 1'b1;
        rr_last_d = 1'b0;
        @(posedge clk); #1;
        burst_pair(0, 0, 0, 1, 32'h8002_0100, 2'b01, 0, "after_midrst");

        repeat (3) @(posedge clk);
        #1;
        chk(acc_q.size() == 0, "acc_q_drained", 32'(acc_q.size()), 0);
        chk(rd_i_q.size() == 0 && rd_d_q.size() == 0, "rd_q_drained",
            32'(rd_i_q.size() + rd_d_q.size()), 0);
        chk(done_q.size() == 0, "done_q_drained", 32'(done_q.size()), 0);
        chk(grant_q.size() == 0, "grant_q_drained", 32'(grant_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "global timeout");
    end

endmodule
